// File: rtl/rx_frame_check_if.sv
// Output handshake of the UART receive check stage: checked byte, its
// error flags and the valid/ready pair towards the host or FIFO.
interface rx_frame_check_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  start_err;
    logic                  stop_err;
    logic                  parity_err;
    logic                  overrun_err;

    modport master (
        output data_out,
        output data_valid,
        output start_err,
        output stop_err,
        output parity_err,
        output overrun_err,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  start_err,
        input  stop_err,
        input  parity_err,
        input  overrun_err,
        output data_ready
    );
endinterface

// File: rtl/rx_frame_check.sv
// UART receive check stage behind the SIPO deserialiser. Captures a frame
// on each rising edge of recieved_flag, checks start/parity/stop, strips
// them and offers the data byte on a valid/ready handshake. A frame that
// arrives while the previous byte is unread is dropped and flagged.
//
// state | meaning
// IDLE  | no byte held, waiting for a frame-complete rise
// CHECK | frame captured, outputs and error flags are loaded this cycle
// HOLD  | byte presented with data_valid=1, waiting for data_ready
module rx_frame_check #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  baud_clk,
    input  logic                  reset_n,
    input  logic [1:0]            parity_type,
    input  logic                  recieved_flag,
    input  logic [DATA_WIDTH+2:0] data_parll,
    rx_frame_check_if.master      rx_if
);
    localparam int FW = DATA_WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_nxt;
    logic                  flag_q;
    logic                  rise;
    logic [FW-1:0]         frame_q;
    logic [1:0]            ptype_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  start_err_q, stop_err_q, parity_err_q, overrun_q;
    logic                  load, accept, set_ovr;
    logic                  par_xor, par_err;

    assign rise    = recieved_flag & ~flag_q;
    assign accept  = valid_q & rx_if.data_ready;
    assign par_xor = ^frame_q[DATA_WIDTH+1:1];

    // Parity check of the captured frame; codes 00 and 11 both mean no parity.
    always_comb begin
        par_err = 1'b0;
        case (ptype_q)
            2'b01:   par_err = ~par_xor;
            2'b10:   par_err = par_xor;
            default: par_err = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    // Next state and datapath strobes; a rise during CHECK is ignored.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        set_ovr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    load      = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: state_nxt = HOLD;
            HOLD: begin
                if (accept) begin
                    if (rise) begin
                        load      = 1'b1;
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (rise) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flag edge register, frame capture and registered outputs.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q       <= 1'b0;
            frame_q      <= '0;
            ptype_q      <= 2'b00;
            data_q       <= '0;
            valid_q      <= 1'b0;
            start_err_q  <= 1'b0;
            stop_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            flag_q <= recieved_flag;
            if (load) begin
                frame_q <= data_parll;
                ptype_q <= parity_type;
            end
            if (state_q == CHECK) begin
                data_q       <= frame_q[DATA_WIDTH:1];
                start_err_q  <= frame_q[0];
                stop_err_q   <= ~frame_q[FW-1];
                parity_err_q <= par_err;
                valid_q      <= 1'b1;
            end
            if (accept) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end else if (set_ovr) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign rx_if.data_out    = data_q;
    assign rx_if.data_valid  = valid_q;
    assign rx_if.start_err   = start_err_q;
    assign rx_if.stop_err    = stop_err_q;
    assign rx_if.parity_err  = parity_err_q;
    assign rx_if.overrun_err = overrun_q;
endmodule
